// File: rtl/layer_seq_pkg.sv
// Shared types and constants for the fixed-point neural layer sequencer.
// Holds the FSM state enum, default geometry and saturation limit helpers.
package layer_seq_pkg;

  localparam int unsigned DEF_FIXED_BITS      = 8;
  localparam int unsigned DEF_FRACTIONAL_BITS = 8;
  localparam int unsigned DEF_NUM_INPUTS      = 4;
  localparam int unsigned DEF_NUM_NEURONS     = 4;
  localparam int unsigned DEF_W               = DEF_FIXED_BITS + DEF_FRACTIONAL_BITS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_GET_IN = 3'd2,
    ST_MAC    = 3'd3,
    ST_EMIT   = 3'd4
  } state_e;

  // Largest and smallest value representable as a w-bit two's complement word.
  function automatic longint sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam longint DEF_SAT_MAX = sat_max(DEF_W);
  localparam longint DEF_SAT_MIN = sat_min(DEF_W);

endpackage

// File: rtl/layer_sequencer_q_mac.sv
// Single-cycle registered fixed-point multiply / arithmetic-shift / accumulate.
// The accumulator is twice the word width and never saturates internally.
module q_mac #(
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  en,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] acc
);

  localparam int unsigned ACC_W = 2 * W;

  logic signed [ACC_W-1:0] w_a_ext;
  logic signed [ACC_W-1:0] w_b_ext;
  logic signed [ACC_W-1:0] w_prod;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] r_acc;

  assign w_a_ext = ACC_W'(a);
  assign w_b_ext = ACC_W'(b);
  assign w_prod  = w_a_ext * w_b_ext;
  assign w_term  = w_prod >>> FRAC;

  // Clear wins over accumulate so a new neuron always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_term;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/layer_sequencer.sv
// Loads a weight matrix, collects an input vector, then emits one saturated
// fixed-point dot product per neuron over a valid/ready output stream.
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int unsigned FIXED_BITS      = DEF_FIXED_BITS,
  parameter int unsigned FRACTIONAL_BITS = DEF_FRACTIONAL_BITS,
  parameter int unsigned NUM_INPUTS      = DEF_NUM_INPUTS,
  parameter int unsigned NUM_NEURONS     = DEF_NUM_NEURONS
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic                                              wload_valid,
  output logic                                              wload_ready,
  input  logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0]      wload_data,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0]      in_data,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic signed [FIXED_BITS+FRACTIONAL_BITS-1:0]      out_data,
  output logic [(NUM_NEURONS>1 ? $clog2(NUM_NEURONS) : 1)-1:0] out_index,
  output logic                                              weights_loaded,
  output logic                                              busy
);

  localparam int unsigned W     = FIXED_BITS + FRACTIONAL_BITS;
  localparam int unsigned ACC_W = 2 * W;
  localparam int unsigned TOTAL = NUM_NEURONS * NUM_INPUTS;
  localparam int unsigned WA_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned XA_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned IC_W  = $clog2(NUM_INPUTS + 1);
  localparam int unsigned NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(W));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(W));

  state_e r_state;
  state_e w_state_nxt;

  logic signed [W-1:0]     r_w [TOTAL];
  logic signed [W-1:0]     r_x [NUM_INPUTS];
  logic [WA_W-1:0]         r_widx, w_widx_nxt;
  logic [XA_W-1:0]         r_xidx, w_xidx_nxt;
  logic [NW-1:0]           r_n, w_n_nxt;
  logic [IC_W-1:0]         r_i, w_i_nxt;
  logic                    r_loaded, w_loaded_nxt;
  logic                    r_wload_ready, r_in_ready, r_busy;
  logic                    r_out_valid, w_out_valid_nxt;
  logic signed [W-1:0]     r_out_data;
  logic [NW-1:0]           r_out_index;

  logic                    w_w_hs, w_in_hs, w_out_hs;
  logic                    w_last_w, w_last_x, w_last_n, w_mac_done;
  logic                    w_w_wr, w_x_wr, w_mac_clear, w_mac_en, w_out_capture;
  logic [XA_W-1:0]         w_i_sel;
  logic [WA_W-1:0]         w_rd_addr;
  logic signed [W-1:0]     w_mac_a, w_mac_b;
  logic signed [ACC_W-1:0] w_acc;
  logic signed [W-1:0]     w_sat;

  assign w_w_hs     = wload_valid & r_wload_ready;
  assign w_in_hs    = in_valid & r_in_ready;
  assign w_out_hs   = r_out_valid & out_ready;
  assign w_last_w   = (r_widx == WA_W'(TOTAL - 1));
  assign w_last_x   = (r_xidx == XA_W'(NUM_INPUTS - 1));
  assign w_last_n   = (r_n == NW'(NUM_NEURONS - 1));
  assign w_mac_done = (r_i == IC_W'(NUM_INPUTS));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a weight offer in IDLE outranks an input offer.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_w_hs) begin
          w_state_nxt = w_last_w ? ST_IDLE : ST_LOAD_W;
        end else if (w_in_hs) begin
          w_state_nxt = w_last_x ? ST_MAC : ST_GET_IN;
        end
      end
      ST_LOAD_W: if (w_w_hs && w_last_w) w_state_nxt = ST_IDLE;
      ST_GET_IN: if (w_in_hs && w_last_x) w_state_nxt = ST_MAC;
      ST_MAC:    if (w_mac_done) w_state_nxt = ST_EMIT;
      ST_EMIT:   if (w_out_hs) w_state_nxt = w_last_n ? ST_IDLE : ST_MAC;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath control. MAC runs NUM_INPUTS accumulate cycles plus one
  // cycle that captures the settled accumulator into the output register.
  always_comb begin
    w_loaded_nxt    = r_loaded;
    w_widx_nxt      = r_widx;
    w_xidx_nxt      = r_xidx;
    w_n_nxt         = r_n;
    w_i_nxt         = r_i;
    w_w_wr          = 1'b0;
    w_x_wr          = 1'b0;
    w_mac_clear     = 1'b0;
    w_mac_en        = 1'b0;
    w_out_capture   = 1'b0;
    w_out_valid_nxt = r_out_valid;
    unique case (r_state)
      ST_IDLE, ST_LOAD_W: begin
        if (w_w_hs) begin
          w_w_wr       = 1'b1;
          w_loaded_nxt = w_last_w;
          w_widx_nxt   = w_last_w ? '0 : r_widx + WA_W'(1);
        end else if ((r_state == ST_IDLE) && w_in_hs) begin
          w_x_wr = 1'b1;
          if (w_last_x) begin
            w_xidx_nxt  = '0;
            w_n_nxt     = '0;
            w_i_nxt     = '0;
            w_mac_clear = 1'b1;
          end else begin
            w_xidx_nxt = r_xidx + XA_W'(1);
          end
        end
      end
      ST_GET_IN: begin
        if (w_in_hs) begin
          w_x_wr = 1'b1;
          if (w_last_x) begin
            w_xidx_nxt  = '0;
            w_n_nxt     = '0;
            w_i_nxt     = '0;
            w_mac_clear = 1'b1;
          end else begin
            w_xidx_nxt = r_xidx + XA_W'(1);
          end
        end
      end
      ST_MAC: begin
        if (!w_mac_done) begin
          w_mac_en = 1'b1;
          w_i_nxt  = r_i + IC_W'(1);
        end else begin
          w_out_capture   = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_i_nxt         = '0;
        end
      end
      ST_EMIT: begin
        if (w_out_hs) begin
          w_out_valid_nxt = 1'b0;
          if (w_last_n) begin
            w_n_nxt = '0;
          end else begin
            w_n_nxt     = r_n + NW'(1);
            w_mac_clear = 1'b1;
          end
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  assign w_i_sel   = XA_W'(r_i);
  assign w_rd_addr = WA_W'((32'(r_n) * NUM_INPUTS) + 32'(w_i_sel));
  assign w_mac_a   = r_x[w_i_sel];
  assign w_mac_b   = r_w[w_rd_addr];

  q_mac #(
    .W    (W),
    .FRAC (FRACTIONAL_BITS)
  ) u_q_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_mac_clear),
    .en    (w_mac_en),
    .a     (w_mac_a),
    .b     (w_mac_b),
    .acc   (w_acc)
  );

  assign w_sat = (w_acc > SAT_MAX) ? W'(SAT_MAX) :
                 (w_acc < SAT_MIN) ? W'(SAT_MIN) : W'(w_acc);

  // Datapath and registered outputs; ready flags track the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_widx        <= '0;
      r_xidx        <= '0;
      r_n           <= '0;
      r_i           <= '0;
      r_loaded      <= 1'b0;
      r_wload_ready <= 1'b1;
      r_in_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_index   <= '0;
      for (int unsigned k = 0; k < TOTAL; k++) r_w[k] <= '0;
      for (int unsigned k = 0; k < NUM_INPUTS; k++) r_x[k] <= '0;
    end else begin
      r_widx        <= w_widx_nxt;
      r_xidx        <= w_xidx_nxt;
      r_n           <= w_n_nxt;
      r_i           <= w_i_nxt;
      r_loaded      <= w_loaded_nxt;
      r_wload_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD_W);
      r_in_ready    <= ((w_state_nxt == ST_IDLE) && w_loaded_nxt) || (w_state_nxt == ST_GET_IN);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_out_valid   <= w_out_valid_nxt;
      if (w_w_wr) r_w[r_widx] <= wload_data;
      if (w_x_wr) r_x[r_xidx] <= in_data;
      if (w_out_capture) begin
        r_out_data  <= w_sat;
        r_out_index <= r_n;
      end
    end
  end

  assign wload_ready    = r_wload_ready;
  assign in_ready       = r_in_ready;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_index      = r_out_index;
  assign weights_loaded = r_loaded;
  assign busy           = r_busy;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed scenarios plus random
// weight/input sets compared against a plain-arithmetic dot-product model.
module tb_layer_sequencer;
  import layer_seq_pkg::*;

  localparam int NI  = 4;
  localparam int NN  = 4;
  localparam int TOT = NI * NN;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wload_valid = 1'b0;
  logic        wload_ready;
  logic [15:0] wload_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [1:0]  out_index;
  logic        weights_loaded;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_w [TOT];
  logic [15:0] m_x [NI];
  logic [15:0] wv [TOT];
  logic [15:0] xv [NI];

  layer_sequencer #(
    .FIXED_BITS      (8),
    .FRACTIONAL_BITS (8),
    .NUM_INPUTS      (NI),
    .NUM_NEURONS     (NN)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wload_valid    (wload_valid),
    .wload_ready    (wload_ready),
    .wload_data     (wload_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_index      (out_index),
    .weights_loaded (weights_loaded),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Dot product of neuron n with Q8.8 scaling, saturated to 16-bit signed.
  function automatic logic [15:0] model_out(input int n);
    longint acc = 0;
    longint p;
    for (int i = 0; i < NI; i++) begin
      p = longint'($signed(m_x[i])) * longint'($signed(m_w[n*NI + i]));
      acc += p >>> 8;
    end
    if (acc > DEF_SAT_MAX) return 16'h7FFF;
    if (acc < DEF_SAT_MIN) return 16'h8000;
    return 16'(acc);
  endfunction

  task automatic send_w(input logic [15:0] d);
    int c = 0;
    wload_valid = 1'b1;
    wload_data  = d;
    @(negedge clk);
    while (!wload_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!wload_ready) check("wload_wait", 32'(wload_ready), 32'd1);
    @(posedge clk);
    #1;
    wload_valid = 1'b0;
  endtask

  task automatic send_x(input logic [15:0] d);
    int c = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready) check("in_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_all(input logic [15:0] v [TOT]);
    for (int k = 0; k < TOT; k++) send_w(v[k]);
    m_w = v;
    check("loaded_after_load", 32'(weights_loaded), 32'd1);
    check("in_ready_after_load", 32'(in_ready), 32'd1);
  endtask

  task automatic send_inputs(input logic [15:0] v [NI]);
    for (int k = 0; k < NI; k++) send_x(v[k]);
    m_x = v;
  endtask

  // Drains all neuron results, optionally with random back-pressure.
  task automatic collect(input bit rnd, input string tag);
    for (int n = 0; n < NN; n++) begin
      int c = 0;
      while (c < 200) begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid && out_ready) break;
        @(posedge clk);
        #1;
        c++;
      end
      if (!out_valid) check({tag, "_out_wait"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(out_data), 32'(model_out(n)));
      check({tag, "_index"}, 32'(out_index), 32'(n));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic probe_no_accept(input string tag);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    check({tag, "_loaded"}, 32'(weights_loaded), 32'd0);
  endtask

  initial begin
    int c;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_wload_ready", 32'(wload_ready), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_loaded", 32'(weights_loaded), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    probe_no_accept("noweights");

    // Unity weights, mixed inputs
    for (int k = 0; k < TOT; k++) wv[k] = 16'h0100;
    load_all(wv);
    xv = '{16'h0100, 16'h0200, 16'h0080, 16'hFF00};
    send_inputs(xv);
    c = 0;
    while (!out_valid && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("latency", 32'(c), 32'd5);
    collect(1'b0, "unity");

    // Positive and negative saturation
    for (int k = 0; k < TOT; k++) wv[k] = 16'h7F00;
    load_all(wv);
    xv = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00};
    send_inputs(xv);
    collect(1'b0, "sat_pos");
    xv = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    send_inputs(xv);
    collect(1'b0, "sat_neg");

    // Back-pressure hold in EMIT
    for (int k = 0; k < TOT; k++) wv[k] = 16'($urandom_range(0, 2047)) - 16'd1024;
    load_all(wv);
    for (int k = 0; k < NI; k++) xv[k] = 16'($urandom_range(0, 2047)) - 16'd1024;
    out_ready = 1'b0;
    send_inputs(xv);
    c = 0;
    while (!out_valid && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(model_out(0)));
      check("hold_index", 32'(out_index), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    collect(1'b0, "hold_drain");

    // Weight load beats a simultaneous input offer
    for (int k = 0; k < TOT; k++) wv[k] = 16'($urandom_range(0, 1023)) - 16'd512;
    in_valid = 1'b1;
    in_data  = 16'h0400;
    send_w(wv[0]);
    check("prio_loaded_drop", 32'(weights_loaded), 32'd0);
    check("prio_busy", 32'(busy), 32'd1);
    for (int k = 1; k < TOT; k++) begin
      check("prio_in_ready", 32'(in_ready), 32'd0);
      send_w(wv[k]);
    end
    in_valid = 1'b0;
    m_w = wv;
    check("prio_loaded_back", 32'(weights_loaded), 32'd1);
    for (int k = 0; k < NI; k++) xv[k] = 16'($urandom_range(0, 1023)) - 16'd512;
    send_inputs(xv);
    collect(1'b0, "prio_run");

    // Random weight/input sets with random back-pressure
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < TOT; k++)
        wv[k] = (r == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 2047)) - 16'd1024;
      load_all(wv);
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < NI; k++)
          xv[k] = (r == 0) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 4095)) - 16'd2048;
        send_inputs(xv);
        collect(1'b1, "rand");
      end
    end

    // Asynchronous reset two cycles into MAC
    send_inputs(xv);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_loaded", 32'(weights_loaded), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_wload_ready", 32'(wload_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_index", 32'(out_index), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    probe_no_accept("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 The block SHALL have parameters, one per line: FIXED_BITS, default 8, integer bits; FRACTIONAL_BITS, default 8, fraction bits; NUM_INPUTS, default 4, inputs per neuron; NUM_NEURONS, default 4, neurons in layer. W = FIXED_BITS+FRACTIONAL_BITS.
REQ-002 The ports SHALL be, one per line:
- clk  in  1  clock;
- rst_n  in  1  reset, asynchronous, active-low;
- wload_valid  in  1  weight word offered;
- wload_ready  out  1  weight word accepted;
- wload_data  in  W  signed weight word;
- in_valid  in  1  input word offered;
- in_ready  out  1  input word accepted;
- in_data  in  W  signed input word;
- out_valid  out  1  neuron result offered;
- out_ready  in  1  result consumed;
- out_data  out  W  signed, saturated result;
- out_index  out  clog2(NUM_NEURONS)  neuron number of out_data;
- weights_loaded  out  1  full weight set present;
- busy  out  1  state not IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD_W, GET_IN, MAC, EMIT.
REQ-004 A handshake SHALL complete on a clk edge with valid and ready both high; valid-side data SHALL be sampled only on that edge.
REQ-005 In IDLE, wload_ready SHALL be 1, and in_ready SHALL be 1 only when weights_loaded=1.
REQ-006 In IDLE, when wload_valid and in_valid are both high, weight load SHALL take priority.
REQ-007 A weight handshake in IDLE SHALL do the following:
- clear weights_loaded;
- write word 0;
- enter LOAD_W.
REQ-008 In LOAD_W, wload_ready SHALL be 1, in_ready SHALL be 0, and words SHALL be stored row-major at w[n][i], index n*NUM_INPUTS+i.
REQ-009 After word NUM_NEURONS*NUM_INPUTS-1 is accepted, the next cycle SHALL set weights_loaded=1 and return to IDLE.
REQ-010 An input handshake in IDLE SHALL store x[0] and enter GET_IN.
REQ-011 In GET_IN, in_ready SHALL be 1 and wload_ready SHALL be 0 until x[NUM_INPUTS-1] is stored; the block SHALL then enter MAC with n=0.
REQ-012 MAC SHALL take exactly NUM_INPUTS cycles per neuron:
- accumulator cleared at entry;
- each cycle acc += (x[i]*w[n][i]) >>> FRACTIONAL_BITS, product 2W signed, arithmetic shift, 2W-bit accumulator, no intermediate saturation;
- the block then enters EMIT.
REQ-013 In EMIT, out_valid SHALL be 1 and out_data SHALL equal acc saturated to W-bit signed range (max 2^(W-1)-1, min -2^(W-1)).
REQ-014 In EMIT, out_index SHALL equal n.
REQ-015 While out_valid=1 and out_ready=0, out_data and out_index SHALL remain stable.
REQ-016 On the output handshake, if n<NUM_NEURONS-1 the block SHALL enter MAC with n+1; otherwise it SHALL enter IDLE.
REQ-017 Latency from last input handshake to first out_valid SHALL be NUM_INPUTS+1 cycles.
REQ-018 Input and weight handshakes SHALL be ignored (ready low) in MAC and EMIT.
REQ-019 All indices SHALL wrap only through the state transitions above; no index SHALL exceed its bound.
REQ-020 busy SHALL be 1 in every state except IDLE.

Reset
REQ-021 rst_n low SHALL, asynchronously and at any time including mid-load or mid-compute, do the following:
- force state IDLE;
- set all indices, accumulator, out_valid, out_data, out_index and weights_loaded to 0;
- leave wload_ready at its IDLE value.
REQ-022 Weight and input storage SHALL reset to 0.
REQ-023 After reset, in_ready SHALL be 0 until a full weight set is loaded.

Structure
REQ-024 Package layer_seq_pkg SHALL hold:
- FSM state enum;
- default widths;
- saturation limit constants.
REQ-025 Multiply/shift/accumulate SHALL live in sub-module q_mac, with inputs clear, en, a, b and output acc.
REQ-026 q_mac SHALL be a single-cycle registered stage.
REQ-027 Saturation SHALL be in the top level.
REQ-028 Weight storage SHALL be a register array indexed by n*NUM_INPUTS+i.

Verification
REQ-029 Defaults, 16 weights 0x0100 (1.0), inputs 0x0100, 0x0200, 0x0080, 0xFF00, out_ready=1 -> four outputs 0x0280 (2.5), out_index 0..3, first out_valid 5 cycles after last input.
REQ-030 All weights 0x7F00, inputs all 0x7F00 -> out_data 0x7FFF on every neuron; weights 0x7F00, inputs 0x8000 -> 0x8000.
REQ-031 With out_ready held 0 for 10 cycles in EMIT -> out_valid, out_data and out_index stable, and no new MAC started.
REQ-032 wload_valid and in_valid high together in IDLE with weights loaded -> weight load wins, weights_loaded drops, and in_ready=0 until 16 words accepted.
REQ-033 Reset pulsed after 2 MAC cycles -> all outputs 0, IDLE, weights_loaded=0, and in_ready=0.
REQ-034 After reset, in_valid=1 without weights -> no acceptance, and busy stays 0.
